// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared FSM state type and round-robin helper functions for the arbiter
package mux_arb_pkg;
  localparam int MAX_N = 32;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
  function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
    int idx;
    rr_pick = ptr;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (req[idx]) rr_pick = idx;
      end
    end
  endfunction
  function automatic logic [MAX_N-1:0] onehot(input int idx);
    onehot = MAX_N'(1) << idx;
  endfunction
endpackage

// File: rtl/muxN.sv
// muxN: parameterised N-to-1 single-bit multiplexer
module muxN #(
  parameter int N = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     x,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);
  assign y = x[sel];
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter with bounded hold time driving an N-to-1 mux select
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int SEL_W = $clog2(N),
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     x,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             y
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_e state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, win;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic busy_q, busy_d, at_max, others, rel;
  assign win = SEL_W'(rr_pick(MAX_N'(req), int'(ptr_q), N));
  assign at_max = hcnt_q == HW'(MAX_HOLD - 1);
  assign others = |(req & ~grant_q);
  assign rel = !req[sel_q] || (at_max && others);
  // state and datapath registers, reset has priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      hcnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      hcnt_q <= hcnt_d;
      busy_q <= busy_d;
    end
  end
  // next state: idle arbitrates on any request, grant releases on drop or timeout
  always_comb begin
    state_d = state_q == IDLE ? (|req ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  end
  // grant, select, pointer and hold counter updates
  always_comb begin
    grant_d = grant_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    hcnt_d = hcnt_q;
    busy_d = busy_q;
    if (state_q == IDLE && |req) begin
      grant_d = N'(onehot(int'(win)));
      sel_d = win;
      busy_d = 1'b1;
      hcnt_d = '0;
    end else if (state_q == GRANT && rel) begin
      grant_d = '0;
      busy_d = 1'b0;
      ptr_d = sel_q == SEL_W'(N - 1) ? '0 : sel_q + SEL_W'(1);
    end else if (state_q == GRANT) begin
      hcnt_d = at_max ? '0 : hcnt_q + HW'(1);
    end
  end
  assign grant = grant_q;
  assign sel = sel_q;
  assign busy = busy_q;
  muxN #(.N(N)) u_mux (.x(x), .sel(sel_q), .y(y));
endmodule
